instr_fetch: RTL and testbench

Instruction fetch stage that sits directly downstream of the program counter register. It takes the registered PC, issues in-order requests to instruction memory, and buffers the returned words in a small response FIFO. It presents instructions to decode through a valid/ready handshake. It also computes the value the program counter loads next cycle: hold, PC+4, or a redirect target.

---
 rtl/if_pkg.sv | 14 +
 rtl/if_resp_fifo.sv | 51 +++++
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction fetch stage.
//   ILEN          instruction / entry field width
//   PC_STEP       sequential PC increment
//   if_state_e    fetch FSM states (FAULT only reachable with IF_MISALIGN_FAULT_EN)
//   fetch_entry_t buffered response {pc, instr}
package if_pkg;
  localparam int ILEN = 32;
  localparam int PC_STEP = 4;
  typedef enum logic {FETCH, FAULT} if_state_e;
  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_resp_fifo.sv
// if_resp_fifo: small synchronous FIFO with flush, used for fetch responses and in-flight PCs.
//   clk, reset (async, active-low)
//   push_i/data_i  write one entry (accepted when not full, or full with a pop)
//   pop_i          drop the head (ignored when empty)
//   flush_i        empty the FIFO; wins over push and pop
//   full_o, empty_o, count_o, head_o  status and head entry
module if_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [W-1:0]             head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign empty_o = count_q == '0;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign count_o = count_q;
  assign head_o = mem_q[rd_q];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: in-order instruction fetch with credit-limited requests and a response FIFO.
//   clk, reset (async, active-low)
//   pc_i / pc_next_o                       current PC in, PC to load next edge out
//   imem_req_o/addr_o/gnt_i                request channel (addr always equals pc_i)
//   imem_rvalid_i/rdata_i                  in-order response channel
//   redirect_i/redirect_pc_i               flush and restart at a new target
//   id_valid_o/ready_i/instr_o/pc_o        decode handshake
//   id_fault_o                             only with IF_MISALIGN_FAULT_EN: misaligned-target fault beat
// XLEN must equal if_pkg::ILEN (buffered entries use fetch_entry_t).
module instr_fetch
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN = ILEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o
`ifdef IF_MISALIGN_FAULT_EN
  ,
  output logic            id_fault_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  logic [CW-1:0] outst, fcnt, discard_q, discard_d;
  logic pcq_full, pcq_empty, resp_full, resp_empty, resp_push, resp_pop;
  logic accept, fetching, fault_beat;
  logic [XLEN-1:0] rsp_pc, redir_tgt, fault_pc;
  fetch_entry_t head;
  assign imem_addr_o = pc_i;
  // Credits use registered counts, so a pop this cycle frees its slot only next cycle.
  assign imem_req_o = reset & fetching & ~redirect_i & (({1'b0, outst} + {1'b0, fcnt}) < DEPTH_C);
  assign accept = imem_req_o & imem_gnt_i;
  assign resp_push = imem_rvalid_i & (discard_q == '0) & ~redirect_i;
  assign resp_pop = id_ready_i & ~resp_empty;
  // On redirect every request still in flight after this cycle's issue/response is stale.
  assign discard_d = redirect_i ? outst + CW'(accept) - CW'(imem_rvalid_i)
                                : discard_q - CW'(imem_rvalid_i & (discard_q != '0));
  assign pc_next_o = !reset ? pc_i : redirect_i ? redir_tgt : accept ? pc_i + XLEN'(PC_STEP) : pc_i;
  assign id_valid_o = ~resp_empty | fault_beat;
  assign id_instr_o = resp_empty ? '0 : head.instr;
  assign id_pc_o = fault_beat ? fault_pc : resp_empty ? '0 : head.pc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) discard_q <= '0;
    else discard_q <= discard_d;
  end
  // In-flight PC queue: never flushed, its count is the outstanding-request count.
  if_resp_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_pcq (
    .clk(clk), .reset(reset), .push_i(accept), .pop_i(imem_rvalid_i), .flush_i(1'b0),
    .data_i(pc_i), .full_o(pcq_full), .empty_o(pcq_empty), .count_o(outst), .head_o(rsp_pc)
  );
  if_resp_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_resp (
    .clk(clk), .reset(reset), .push_i(resp_push), .pop_i(resp_pop), .flush_i(redirect_i),
    .data_i({rsp_pc, imem_rdata_i}), .full_o(resp_full), .empty_o(resp_empty), .count_o(fcnt),
    .head_o(head)
  );
`ifdef IF_MISALIGN_FAULT_EN
  if_state_e state_q, state_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic fault_pend_q, fault_pend_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      fault_pc_q <= '0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_pc_q <= fault_pc_d;
      fault_pend_q <= fault_pend_d;
    end
  end
  always_comb begin
    state_d = state_q;
    fault_pc_d = fault_pc_q;
    fault_pend_d = fault_pend_q;
    if (redirect_i) begin
      state_d = |redirect_pc_i[1:0] ? FAULT : FETCH;
      fault_pc_d = redirect_pc_i;
      fault_pend_d = |redirect_pc_i[1:0];
    end else if (fault_beat && id_ready_i) begin
      fault_pend_d = 1'b0;
    end
  end
  // The fault beat waits until stale responses have drained.
  assign fault_beat = (state_q == FAULT) & fault_pend_q & (discard_q == '0) & resp_empty;
  assign fetching = state_q == FETCH;
  assign fault_pc = fault_pc_q;
  assign redir_tgt = redirect_pc_i;
  assign id_fault_o = fault_beat;
`else
  assign fault_beat = 1'b0;
  assign fetching = 1'b1;
  assign fault_pc = '0;
  assign redir_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
`endif
  a_resp_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(resp_push && resp_full && !resp_pop));
  a_pcq_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(accept && pcq_full && !imem_rvalid_i));
  a_pcq_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rvalid_i && pcq_empty));
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a PC register and fixed-latency memory model.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] pc_i = '0, pc_next_o, imem_addr_o, imem_rdata_i = '0, redirect_pc_i = '0;
  logic [31:0] id_instr_o, id_pc_o;
  logic imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0, redirect_i = 1'b0;
  logic id_valid_o, id_ready_i = 1'b0;
`ifdef IF_MISALIGN_FAULT_EN
  logic id_fault_o;
`endif
  always #5 clk = ~clk;
  instr_fetch #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .pc_next_o(pc_next_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o)
`ifdef IF_MISALIGN_FAULT_EN
    , .id_fault_o(id_fault_o)
`endif
  );
  typedef struct {
    logic gnt, rdy, req;
    logic [31:0] addr, pcn;
    logic vld;
    logic [31:0] ipc, iins;
  } vec_t;
  typedef struct {
    logic [31:0] a;
    int due;
  } mreq_t;
  mreq_t mq[$];
  int cyc = 0, lat = 1, n_chk = 0, n_fail = 0;
  logic [31:0] pc_nxt;
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1300_0000 ^ a;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // One clock: record an accepted request, load the PC register, present due responses.
  task automatic step();
    #1;
    if (imem_req_o && imem_gnt_i) mq.push_back('{imem_addr_o, cyc + lat});
    pc_nxt = pc_next_o;
    @(posedge clk);
    #1;
    cyc++;
    pc_i = pc_nxt;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i = word(mq[0].a);
      mq.delete(0);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i = '0;
    end
    @(negedge clk);
  endtask
  task automatic do_reset(input logic [31:0] pc0);
    reset = 1'b0;
    mq.delete();
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    redirect_i = 1'b0;
    pc_i = pc0;
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", id_valid_o, 0);
    chk("rst_pcnext", pc_next_o, pc0);
    chk("rst_instr", id_instr_o, 0);
    chk("rst_idpc", id_pc_o, 0);
    step();
    step();
    reset = 1'b1;
    cyc = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tv[13];
    tv[0]  = '{1, 1, 1, 32'h0,  32'h4,  0, 32'h0, 32'h0};
    tv[1]  = '{1, 1, 1, 32'h4,  32'h8,  0, 32'h0, 32'h0};
    tv[2]  = '{1, 1, 0, 32'h8,  32'h8,  1, 32'h0, 32'h1300_0000};
    tv[3]  = '{1, 1, 1, 32'h8,  32'hC,  1, 32'h4, 32'h1300_0004};
    tv[4]  = '{1, 1, 1, 32'hC,  32'h10, 0, 32'h0, 32'h0};
    tv[5]  = '{1, 1, 0, 32'h10, 32'h10, 1, 32'h8, 32'h1300_0008};
    tv[6]  = '{1, 0, 1, 32'h0,  32'h4,  0, 32'h0, 32'h0};
    tv[7]  = '{1, 0, 1, 32'h4,  32'h8,  0, 32'h0, 32'h0};
    tv[8]  = '{1, 0, 0, 32'h8,  32'h8,  1, 32'h0, 32'h1300_0000};
    tv[9]  = '{1, 0, 0, 32'h8,  32'h8,  1, 32'h0, 32'h1300_0000};
    tv[10] = '{1, 0, 0, 32'h8,  32'h8,  1, 32'h0, 32'h1300_0000};
    tv[11] = '{1, 1, 0, 32'h8,  32'h8,  1, 32'h0, 32'h1300_0000};
    tv[12] = '{1, 1, 1, 32'h8,  32'hC,  1, 32'h4, 32'h1300_0004};
    @(negedge clk);
    foreach (tv[i]) begin
      if (i == 0 || i == 6) do_reset(32'h0);
      imem_gnt_i = tv[i].gnt;
      id_ready_i = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_req", i), imem_req_o, tv[i].req);
      chk($sformatf("v%0d_addr", i), imem_addr_o, tv[i].addr);
      chk($sformatf("v%0d_pcnext", i), pc_next_o, tv[i].pcn);
      chk($sformatf("v%0d_valid", i), id_valid_o, tv[i].vld);
      if (tv[i].vld) begin
        chk($sformatf("v%0d_idpc", i), id_pc_o, tv[i].ipc);
        chk($sformatf("v%0d_instr", i), id_instr_o, tv[i].iins);
      end
      step();
    end
    // Redirect with two requests outstanding: both stale words must be dropped.
    do_reset(32'h0);
    lat = 3;
    imem_gnt_i = 1'b1;
    id_ready_i = 1'b1;
    step();
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    chk("redir_req", imem_req_o, 0);
    chk("redir_pcnext", pc_next_o, 32'h100);
    step();
    redirect_i = 1'b0;
    for (int i = 0; i < 20 && !id_valid_o; i++) step();
    chk("redir_first_valid", id_valid_o, 1);
    chk("redir_first_pc", id_pc_o, 32'h100);
    chk("redir_first_instr", id_instr_o, word(32'h100));
    // Grant held low: the request and address hold, the PC does not advance.
    do_reset(32'h0);
    lat = 1;
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("nognt%0d_req", i), imem_req_o, 1);
      chk($sformatf("nognt%0d_addr", i), imem_addr_o, 32'h0);
      chk($sformatf("nognt%0d_pcnext", i), pc_next_o, 32'h0);
      step();
    end
    imem_gnt_i = 1'b1;
    #1;
    chk("gnt_pcnext", pc_next_o, 32'h4);
    // PC wrap at the top of the address space.
    do_reset(32'hFFFF_FFFC);
    #1;
    chk("wrap_req", imem_req_o, 1);
    chk("wrap_pcnext", pc_next_o, 32'h0);
    step();
    #1;
    chk("wrap_addr", imem_addr_o, 32'h0);
    // Misaligned redirect target.
    do_reset(32'h0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h102;
    #1;
    chk("mis_req", imem_req_o, 0);
`ifdef IF_MISALIGN_FAULT_EN
    chk("mis_pcnext", pc_next_o, 32'h102);
    step();
    redirect_i = 1'b0;
    #1;
    chk("fault_valid", id_valid_o, 1);
    chk("fault_flag", id_fault_o, 1);
    chk("fault_pc", id_pc_o, 32'h102);
    chk("fault_instr", id_instr_o, 0);
    chk("fault_req", imem_req_o, 0);
    step();
    chk("fault_once", id_valid_o, 0);
    chk("fault_hold_req", imem_req_o, 0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    #1;
    chk("resume_pcnext", pc_next_o, 32'h200);
    step();
    redirect_i = 1'b0;
    #1;
    chk("resume_req", imem_req_o, 1);
    chk("resume_addr", imem_addr_o, 32'h200);
    chk("resume_fault", id_fault_o, 0);
`else
    chk("mis_pcnext", pc_next_o, 32'h100);
    step();
    redirect_i = 1'b0;
    #1;
    chk("mis_next_req", imem_req_o, 1);
    chk("mis_next_addr", imem_addr_o, 32'h100);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
